// File: rtl/mac_link_test_ctrl_if.sv
// Control/status bundle between the 25GE loopback test sequencer and the MAC,
// GT and packet generator/checker around it.
interface mac_link_test_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             rx_gt_locked;
    logic             rx_block_lock;
    logic             restart_req;
    logic             tx_done;
    logic [CNT_W-1:0] tx_pkt_cnt;
    logic [CNT_W-1:0] rx_pkt_cnt;
    logic [CNT_W-1:0] tx_byte_cnt;
    logic [CNT_W-1:0] rx_byte_cnt;
    logic             bit_err;
    logic             lbus_proto_err;
    logic             gt_reset_out;
    logic             restart_tx_rx;
    logic             link_up;
    logic [4:0]       completion_status;
    logic [1:0]       retry_cnt;

    // Sequencer side
    modport master (
        input  rx_gt_locked, rx_block_lock, restart_req, tx_done,
        input  tx_pkt_cnt, rx_pkt_cnt, tx_byte_cnt, rx_byte_cnt,
        input  bit_err, lbus_proto_err,
        output gt_reset_out, restart_tx_rx, link_up, completion_status, retry_cnt
    );

    // MAC / GT / generator-checker side
    modport slave (
        output rx_gt_locked, rx_block_lock, restart_req, tx_done,
        output tx_pkt_cnt, rx_pkt_cnt, tx_byte_cnt, rx_byte_cnt,
        output bit_err, lbus_proto_err,
        input  gt_reset_out, restart_tx_rx, link_up, completion_status, retry_cnt
    );
endinterface

// File: rtl/mac_link_test_ctrl.sv
// Loopback test sequencer for the single-lane 25GE MAC: brings the GT up with
// lock-timeout retries, runs one generator burst and grades it from the counters.
module mac_link_test_ctrl #(
    parameter int RESET_CYC   = 20,
    parameter int LOCK_TMO_W  = 21,
    parameter int TX_TMO_CYC  = 4194304,
    parameter int RESTART_CYC = 10,
    parameter int DRAIN_CYC   = 1024,
    parameter int MAX_RETRY   = 3
) (
    input  logic                    dclk,
    input  logic                    sys_reset,
    mac_link_test_ctrl_if.master    bus
);

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The one timer must reach the lock-timeout bit and every cycle budget.
    localparam int TMR_W = max_i(max_i(LOCK_TMO_W, $clog2(TX_TMO_CYC + 1)),
                                 max_i($clog2(DRAIN_CYC + 1),
                                       max_i($clog2(RESET_CYC + 1), $clog2(RESTART_CYC + 1))));

    localparam logic [TMR_W-1:0] RESET_LAST   = TMR_W'(RESET_CYC - 1);
    localparam logic [TMR_W-1:0] RESTART_LAST = TMR_W'(RESTART_CYC - 1);
    localparam logic [TMR_W-1:0] DRAIN_LAST   = TMR_W'(DRAIN_CYC - 1);
    localparam logic [TMR_W-1:0] TX_TMO       = TMR_W'(TX_TMO_CYC);
    localparam logic [1:0]       MAX_RETRY_V  = 2'(MAX_RETRY);

    localparam logic [4:0] STS_NONE      = 5'd0;
    localparam logic [4:0] STS_PASS      = 5'd1;
    localparam logic [4:0] STS_LOCK_TMO  = 5'd2;
    localparam logic [4:0] STS_LINK_LOST = 5'd4;
    localparam logic [4:0] STS_TX_TMO    = 5'd10;
    localparam logic [4:0] STS_NO_TX     = 5'd11;
    localparam logic [4:0] STS_PKT_MIS   = 5'd12;
    localparam logic [4:0] STS_BYTE_MIS  = 5'd13;
    localparam logic [4:0] STS_PROTO     = 5'd14;
    localparam logic [4:0] STS_BIT_ERR   = 5'd15;
    localparam logic [4:0] STS_RESET     = 5'h1F;

    typedef enum logic [3:0] {
        ST_RST_HOLD = 4'd0,
        ST_WAIT_GT  = 4'd1,
        ST_WAIT_BLK = 4'd2,
        ST_START    = 4'd3,
        ST_RUN      = 4'd4,
        ST_DRAIN    = 4'd5,
        ST_CHECK    = 4'd6,
        ST_DONE     = 4'd7,
        ST_FAIL     = 4'd8
    } state_t;

    state_t             state_r;
    state_t             state_nxt;
    logic               gt_meta_r;
    logic               blk_meta_r;
    logic               rx_gt_locked_s;
    logic               rx_block_lock_s;
    logic [TMR_W-1:0]   timer_r;
    logic [TMR_W-1:0]   timer_nxt;
    logic               proto_err_r;
    logic               proto_nxt;
    logic               lock_tmo_s;
    logic               retry_left_s;
    logic [4:0]         check_code_s;
    logic               gt_reset_out_r;
    logic               restart_tx_rx_r;
    logic               link_up_r;
    logic [4:0]         status_r;
    logic [1:0]         retry_cnt_r;
    logic               gt_reset_nxt;
    logic               restart_nxt;
    logic               link_up_nxt;
    logic [4:0]         status_nxt;
    logic [1:0]         retry_nxt;

    assign lock_tmo_s   = timer_r[LOCK_TMO_W-1];
    assign retry_left_s = (retry_cnt_r < MAX_RETRY_V);

    // Two-flop synchronisers for the asynchronous lock indications
    always_ff @(posedge dclk or posedge sys_reset) begin
        if (sys_reset) begin
            gt_meta_r       <= 1'b0;
            blk_meta_r      <= 1'b0;
            rx_gt_locked_s  <= 1'b0;
            rx_block_lock_s <= 1'b0;
        end else begin
            gt_meta_r       <= bus.rx_gt_locked;
            blk_meta_r      <= bus.rx_block_lock;
            rx_gt_locked_s  <= gt_meta_r;
            rx_block_lock_s <= blk_meta_r;
        end
    end

    // FSM state register
    always_ff @(posedge dclk or posedge sys_reset) begin
        if (sys_reset) begin
            state_r <= ST_RST_HOLD;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_RST_HOLD: begin
                if (timer_r == RESET_LAST) state_nxt = ST_WAIT_GT;
                else                       state_nxt = ST_RST_HOLD;
            end
            ST_WAIT_GT: begin
                if (rx_gt_locked_s)   state_nxt = ST_WAIT_BLK;
                else if (lock_tmo_s)  state_nxt = retry_left_s ? ST_RST_HOLD : ST_FAIL;
                else                  state_nxt = ST_WAIT_GT;
            end
            ST_WAIT_BLK: begin
                if (rx_block_lock_s)      state_nxt = ST_START;
                else if (lock_tmo_s)      state_nxt = retry_left_s ? ST_RST_HOLD : ST_FAIL;
                else if (!rx_gt_locked_s) state_nxt = ST_WAIT_GT;
                else                      state_nxt = ST_WAIT_BLK;
            end
            ST_START: begin
                if (timer_r == RESTART_LAST) state_nxt = ST_RUN;
                else                         state_nxt = ST_START;
            end
            ST_RUN: begin
                // Link loss wins over a tx_done in the same cycle.
                if (!rx_block_lock_s)      state_nxt = ST_FAIL;
                else if (bus.tx_done)      state_nxt = ST_DRAIN;
                else if (timer_r == TX_TMO) state_nxt = ST_FAIL;
                else                       state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                if (!rx_block_lock_s)        state_nxt = ST_FAIL;
                else if (timer_r == DRAIN_LAST) state_nxt = ST_CHECK;
                else                         state_nxt = ST_DRAIN;
            end
            ST_CHECK: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.restart_req) state_nxt = rx_block_lock_s ? ST_START : ST_WAIT_BLK;
                else                 state_nxt = ST_DONE;
            end
            ST_FAIL: begin
                if (bus.restart_req) state_nxt = ST_RST_HOLD;
                else                 state_nxt = ST_FAIL;
            end
            default: begin
                state_nxt = ST_RST_HOLD;
            end
        endcase
    end

    // Burst grading, first match wins
    always_comb begin
        if (proto_err_r)                                 check_code_s = STS_PROTO;
        else if (bus.tx_pkt_cnt == '0)                   check_code_s = STS_NO_TX;
        else if (bus.tx_pkt_cnt != bus.rx_pkt_cnt)       check_code_s = STS_PKT_MIS;
        else if (bus.tx_byte_cnt != bus.rx_byte_cnt)     check_code_s = STS_BYTE_MIS;
        else if (bus.bit_err)                            check_code_s = STS_BIT_ERR;
        else                                             check_code_s = STS_PASS;
    end

    // Timer and protocol-error latch; WAIT_BLK falling back to WAIT_GT keeps the timer running
    always_comb begin
        if ((state_nxt != state_r) &&
            !((state_r == ST_WAIT_BLK) && (state_nxt == ST_WAIT_GT))) begin
            timer_nxt = '0;
        end else if (&timer_r) begin
            timer_nxt = timer_r;
        end else begin
            timer_nxt = timer_r + TMR_W'(1);
        end

        if (state_r == ST_START)      proto_nxt = 1'b0;
        else if (bus.lbus_proto_err)  proto_nxt = 1'b1;
        else                          proto_nxt = proto_err_r;
    end

    // Datapath registers
    always_ff @(posedge dclk or posedge sys_reset) begin
        if (sys_reset) begin
            timer_r     <= '0;
            proto_err_r <= 1'b0;
        end else begin
            timer_r     <= timer_nxt;
            proto_err_r <= proto_nxt;
        end
    end

    // FSM output logic, decoded from the next state so registered outputs align with it
    always_comb begin
        gt_reset_nxt = (state_nxt == ST_RST_HOLD);
        restart_nxt  = (state_nxt == ST_START);
        if ((state_nxt == ST_RUN) || (state_nxt == ST_DRAIN) ||
            (state_nxt == ST_CHECK) || (state_nxt == ST_DONE)) begin
            link_up_nxt = rx_block_lock_s;
        end else begin
            link_up_nxt = 1'b0;
        end
        status_nxt = status_r;
        retry_nxt  = retry_cnt_r;
        case (state_r)
            ST_RST_HOLD: begin
                status_nxt = STS_NONE;
            end
            ST_WAIT_GT, ST_WAIT_BLK: begin
                if (state_nxt == ST_RST_HOLD)  retry_nxt  = retry_cnt_r + 2'd1;
                else if (state_nxt == ST_FAIL) status_nxt = STS_LOCK_TMO;
                else                           status_nxt = status_r;
            end
            ST_RUN: begin
                if (state_nxt == ST_FAIL) status_nxt = rx_block_lock_s ? STS_TX_TMO : STS_LINK_LOST;
                else                      status_nxt = status_r;
            end
            ST_DRAIN: begin
                if (state_nxt == ST_FAIL) status_nxt = STS_LINK_LOST;
                else                      status_nxt = status_r;
            end
            ST_CHECK: begin
                status_nxt = check_code_s;
            end
            ST_DONE: begin
                if (state_nxt != ST_DONE) status_nxt = STS_NONE;
                else                      status_nxt = status_r;
            end
            ST_FAIL: begin
                if (state_nxt != ST_FAIL) begin
                    status_nxt = STS_NONE;
                    retry_nxt  = 2'd0;
                end else begin
                    status_nxt = status_r;
                end
            end
            default: begin
                status_nxt = STS_NONE;
                retry_nxt  = 2'd0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge dclk or posedge sys_reset) begin
        if (sys_reset) begin
            gt_reset_out_r  <= 1'b1;
            restart_tx_rx_r <= 1'b0;
            link_up_r       <= 1'b0;
            status_r        <= STS_RESET;
            retry_cnt_r     <= 2'd0;
        end else begin
            gt_reset_out_r  <= gt_reset_nxt;
            restart_tx_rx_r <= restart_nxt;
            link_up_r       <= link_up_nxt;
            status_r        <= status_nxt;
            retry_cnt_r     <= retry_nxt;
        end
    end

    assign bus.gt_reset_out      = gt_reset_out_r;
    assign bus.restart_tx_rx     = restart_tx_rx_r;
    assign bus.link_up           = link_up_r;
    assign bus.completion_status = status_r;
    assign bus.retry_cnt         = retry_cnt_r;

endmodule

// File: tb/tb_mac_link_test_ctrl.sv
// Directed bench for mac_link_test_ctrl: table of burst-grading vectors plus
// hand sequences for bring-up, retries, link loss, TX timeout and mid-run reset.
module tb_mac_link_test_ctrl;

    logic dclk;
    logic sys_reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    mac_link_test_ctrl_if #(.CNT_W(32)) bus ();

    mac_link_test_ctrl #(
        .RESET_CYC   (20),
        .LOCK_TMO_W  (8),
        .TX_TMO_CYC  (500),
        .RESTART_CYC (10),
        .DRAIN_CYC   (16),
        .MAX_RETRY   (3)
    ) dut (
        .dclk      (dclk),
        .sys_reset (sys_reset),
        .bus       (bus)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;
    always @(posedge dclk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] tx_pkt;
        logic [31:0] rx_pkt;
        logic [31:0] tx_byte;
        logic [31:0] rx_byte;
        logic        bit_err;
        logic        proto;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic pulse_restart();
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
    endtask

    // Waits for the restart pulse and returns its width; returns just after RUN entry.
    task automatic wait_run(output int width);
        int n;
        n = 0;
        width = 0;
        while (bus.restart_tx_rx !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        while (bus.restart_tx_rx === 1'b1 && width < 50) begin
            tick();
            width++;
        end
    endtask

    task automatic tx_done_and_wait(output int lat);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        lat = 0;
        while (bus.completion_status === 5'd0 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int w;
        int lat;
        bus.tx_pkt_cnt  = v.tx_pkt;
        bus.rx_pkt_cnt  = v.rx_pkt;
        bus.tx_byte_cnt = v.tx_byte;
        bus.rx_byte_cnt = v.rx_byte;
        bus.bit_err     = v.bit_err;
        pulse_restart();
        check($sformatf("vec%0d_status_clr", idx), 32'(bus.completion_status), 32'd0);
        wait_run(w);
        check($sformatf("vec%0d_restart_width", idx), 32'(w), 32'd10);
        repeat (20) tick();
        if (v.proto) begin
            bus.lbus_proto_err = 1'b1;
            tick();
            bus.lbus_proto_err = 1'b0;
        end
        repeat (5) tick();
        tx_done_and_wait(lat);
        check($sformatf("vec%0d_status", idx), 32'(bus.completion_status), 32'(v.exp));
        check($sformatf("vec%0d_link_up", idx), 32'(bus.link_up), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int lock_cyc;
        int pulses;
        int bad_w;
        int hw;

        //            tx_pkt        rx_pkt        tx_byte       rx_byte      bit proto exp
        vecs[0]  = '{32'd1000,     32'd999,      32'd64000,    32'd64000,    1'b0, 1'b0, 5'd12};
        vecs[1]  = '{32'd1000,     32'd999,      32'd64000,    32'd64000,    1'b1, 1'b0, 5'd12};
        vecs[2]  = '{32'd1000,     32'd999,      32'd64000,    32'd64000,    1'b1, 1'b1, 5'd14};
        vecs[3]  = '{32'd1000,     32'd1000,     32'd64000,    32'd64000,    1'b0, 1'b0, 5'd1};
        vecs[4]  = '{32'd0,        32'd0,        32'd0,        32'd0,        1'b0, 1'b0, 5'd11};
        vecs[5]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b1, 1'b0, 5'd11};
        vecs[6]  = '{32'd1000,     32'd1000,     32'd64000,    32'd63936,    1'b0, 1'b0, 5'd13};
        vecs[7]  = '{32'd1000,     32'd1000,     32'd64000,    32'd64000,    1'b1, 1'b0, 5'd15};
        vecs[8]  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd64000,    32'd64000,    1'b0, 1'b0, 5'd12};
        vecs[9]  = '{32'd1000,     32'd1000,     32'h80000000, 32'h00000000, 1'b1, 1'b0, 5'd13};
        vecs[10] = '{32'd0,        32'd0,        32'd0,        32'd0,        1'b0, 1'b1, 5'd14};
        vecs[11] = '{32'd1000,     32'd1000,     32'd64000,    32'd64000,    1'b0, 1'b0, 5'd1};

        sys_reset          = 1'b1;
        bus.rx_gt_locked   = 1'b0;
        bus.rx_block_lock  = 1'b0;
        bus.restart_req    = 1'b0;
        bus.tx_done        = 1'b0;
        bus.tx_pkt_cnt     = 32'd1000;
        bus.rx_pkt_cnt     = 32'd1000;
        bus.tx_byte_cnt    = 32'd64000;
        bus.rx_byte_cnt    = 32'd64000;
        bus.bit_err        = 1'b0;
        bus.lbus_proto_err = 1'b0;
        repeat (3) tick();

        check("rst_gt_reset", 32'(bus.gt_reset_out), 32'd1);
        check("rst_restart", 32'(bus.restart_tx_rx), 32'd0);
        check("rst_link_up", 32'(bus.link_up), 32'd0);
        check("rst_status", 32'(bus.completion_status), 32'h1F);
        check("rst_retry", 32'(bus.retry_cnt), 32'd0);

        // Nominal pass: locks at cycle 30, tx_done 200 cycles later
        sys_reset = 1'b0;
        tick();
        check("status_after_rst", 32'(bus.completion_status), 32'd0);
        repeat (29) tick();
        lock_cyc = cyc;
        bus.rx_gt_locked  = 1'b1;
        bus.rx_block_lock = 1'b1;
        wait_run(w);
        check("nom_restart_width", 32'(w), 32'd10);
        check("nom_link_up_run", 32'(bus.link_up), 32'd1);
        while (cyc < lock_cyc + 199) tick();
        tx_done_and_wait(n);
        check("nom_drain_latency", 32'(n), 32'd17);
        check("nom_status", 32'(bus.completion_status), 32'd1);
        check("nom_link_up", 32'(bus.link_up), 32'd1);
        check("nom_retry", 32'(bus.retry_cnt), 32'd0);

        // Reset in the middle of the restart pulse
        pulse_restart();
        check("mid_restart_high", 32'(bus.restart_tx_rx), 32'd1);
        repeat (4) tick();
        sys_reset = 1'b1;
        #1;
        check("mid_rst_restart", 32'(bus.restart_tx_rx), 32'd0);
        check("mid_rst_status", 32'(bus.completion_status), 32'h1F);
        check("mid_rst_gt_reset", 32'(bus.gt_reset_out), 32'd1);
        tick();
        sys_reset = 1'b0;
        tick();
        check("mid_rst_status_clr", 32'(bus.completion_status), 32'd0);
        wait_run(w);
        check("mid_rst_restart_width", 32'(w), 32'd10);
        repeat (30) tick();
        tx_done_and_wait(n);
        check("mid_rst_pass", 32'(bus.completion_status), 32'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Block lock lost 50 cycles into RUN, coinciding with tx_done at the FSM
        bus.tx_pkt_cnt = 32'd1000;
        bus.rx_pkt_cnt = 32'd1000;
        bus.bit_err    = 1'b0;
        pulse_restart();
        wait_run(w);
        check("blk_restart_width", 32'(w), 32'd10);
        repeat (50) tick();
        bus.rx_block_lock = 1'b0;
        tick();
        tick();
        check("blk_status_pre", 32'(bus.completion_status), 32'd0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("blk_status", 32'(bus.completion_status), 32'd4);
        check("blk_link_up", 32'(bus.link_up), 32'd0);
        repeat (30) tick();
        check("blk_status_held", 32'(bus.completion_status), 32'd4);

        bus.rx_block_lock = 1'b1;
        pulse_restart();
        check("blk_restart_gt_reset", 32'(bus.gt_reset_out), 32'd1);
        check("blk_restart_status", 32'(bus.completion_status), 32'd0);

        // No tx_done: TX timeout; a restart_req in RUN must be ignored
        wait_run(w);
        check("tmo_restart_width", 32'(w), 32'd10);
        n = 0;
        while (bus.completion_status === 5'd0 && n < 700) begin
            bus.restart_req = (n == 100);
            tick();
            n++;
        end
        bus.restart_req = 1'b0;
        check("tmo_latency_ok", 32'(n >= 500 && n <= 501), 32'd1);
        check("tmo_status", 32'(bus.completion_status), 32'd10);
        pulse_restart();
        check("tmo_restart_gt_reset", 32'(bus.gt_reset_out), 32'd1);
        check("tmo_restart_status", 32'(bus.completion_status), 32'd0);

        // GT lock never rises: four 20-cycle reset pulses, then lock timeout
        bus.rx_gt_locked  = 1'b0;
        bus.rx_block_lock = 1'b0;
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        pulses = 0;
        bad_w  = 0;
        hw     = 0;
        for (int i = 0; i < 2000 && bus.completion_status !== 5'd2; i++) begin
            if (bus.gt_reset_out === 1'b1) begin
                hw++;
            end else if (hw != 0) begin
                pulses++;
                if (hw != 20) bad_w++;
                hw = 0;
            end
            tick();
        end
        check("nolock_status", 32'(bus.completion_status), 32'd2);
        check("nolock_pulses", 32'(pulses), 32'd4);
        check("nolock_bad_widths", 32'(bad_w), 32'd0);
        check("nolock_retry", 32'(bus.retry_cnt), 32'd3);
        check("nolock_gt_reset", 32'(bus.gt_reset_out), 32'd0);

        // Recovery from FAIL once the locks come up
        bus.rx_gt_locked  = 1'b1;
        bus.rx_block_lock = 1'b1;
        pulse_restart();
        check("recover_retry", 32'(bus.retry_cnt), 32'd0);
        check("recover_status", 32'(bus.completion_status), 32'd0);
        wait_run(w);
        check("recover_restart_width", 32'(w), 32'd10);
        check("recover_link_up", 32'(bus.link_up), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
